ir_packet_decoder: RTL

Receive-side decoder for the IR remote-control packet whose transmission is paced by the 10 Hz SEND_PACKET trigger. Takes the demodulated IR envelope (high = carrier burst present) and measures burst and gap lengths in prescaled ticks. Validates the start burst and inter-burst gaps, then classifies each data burst as 0 or 1. Presents the decoded command word with a one-cycle valid strobe, or a one-cycle error strobe on any timing violation.

---
 rtl/ir_packet_decoder_if.sv | 15 +
 rtl/ir_packet_decoder.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/ir_packet_decoder_if.sv
// Control/status bundle between the IR decoder and its host.
// Line envelope and enable go in; the decoded command and its strobes come out.
interface ir_packet_decoder_if #(
  parameter int NUM_BITS = 5
);
  logic                ENABLE;
  logic                IR_IN;
  logic [NUM_BITS-1:0] CMD;
  logic                CMD_VALID;
  logic                ERR;
  logic                BUSY;

  modport master (output ENABLE, IR_IN, input  CMD, CMD_VALID, ERR, BUSY);
  modport slave  (input  ENABLE, IR_IN, output CMD, CMD_VALID, ERR, BUSY);
endinterface

// File: rtl/ir_packet_decoder.sv
// IR packet receiver: measures burst/gap lengths in prescaled ticks, checks
// start and gap timing, and decodes each data burst as a 0 or a 1.
module ir_packet_decoder #(
  parameter int TICK_DIV  = 1000,
  parameter int NUM_BITS  = 5,
  parameter int START_MIN = 80,
  parameter int START_MAX = 96,
  parameter int GAP_MIN   = 32,
  parameter int GAP_MAX   = 48,
  parameter int ZERO_MIN  = 18,
  parameter int ZERO_MAX  = 26,
  parameter int ONE_MIN   = 38,
  parameter int ONE_MAX   = 50
) (
  input logic                CLK,
  input logic                RESET,
  ir_packet_decoder_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IW = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;

  typedef enum logic [1:0] {IDLE, START, GAP, DATA} state_t;

  state_t              state;
  logic [2:0]          ir_pipe;   // [1:0] synchroniser, [2] history
  logic [PW-1:0]       presc;
  logic [7:0]          cnt;
  logic [IW-1:0]       bit_idx;
  logic [NUM_BITS-1:0] shreg;
  logic [NUM_BITS-1:0] cmd;
  logic                cmd_valid;
  logic                err;

  logic rise, fall, tick;
  logic start_ok, gap_short, in_zero, in_one;
  logic [NUM_BITS-1:0] sh_nxt;

  assign rise = ir_pipe[1] & ~ir_pipe[2];
  assign fall = ~ir_pipe[1] & ir_pipe[2];
  assign tick = (presc == PW'(TICK_DIV - 1));

  assign start_ok  = (cnt >= 8'(START_MIN)) && (cnt <= 8'(START_MAX));
  assign gap_short = (cnt < 8'(GAP_MIN));
  assign in_zero   = (cnt >= 8'(ZERO_MIN)) && (cnt <= 8'(ZERO_MAX));
  assign in_one    = (cnt >= 8'(ONE_MIN))  && (cnt <= 8'(ONE_MAX));
  assign sh_nxt    = {shreg[NUM_BITS-2:0], in_one};

  // Line conditioning and time base; independent of ENABLE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ir_pipe <= '0;
      presc   <= '0;
      cnt     <= '0;
    end else begin
      ir_pipe <= {ir_pipe[1:0], bus.IR_IN};
      presc   <= tick ? '0 : presc + PW'(1);
      if (rise || fall)
        cnt <= '0;
      else if (tick && cnt != 8'hFF)
        cnt <= cnt + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      bit_idx   <= '0;
      shreg     <= '0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (!bus.ENABLE) begin
        state   <= IDLE;
        bit_idx <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          IDLE: begin
            // Only a fresh rise starts a packet, so a burst already high at
            // abort time can never be taken for a start burst.
            if (rise) state <= START;
          end
          START: begin
            if (fall) begin
              if (start_ok) begin
                state   <= GAP;
                bit_idx <= '0;
              end else begin
                state <= IDLE;
                err   <= 1'b1;
              end
            end else if (cnt > 8'(START_MAX)) begin
              state <= IDLE;
              err   <= 1'b1;
            end
          end
          GAP: begin
            if (rise) begin
              if (gap_short) begin
                state   <= IDLE;
                err     <= 1'b1;
                bit_idx <= '0;
                shreg   <= '0;
              end else begin
                state <= DATA;
              end
            end else if (cnt > 8'(GAP_MAX)) begin
              state   <= IDLE;
              err     <= 1'b1;
              bit_idx <= '0;
              shreg   <= '0;
            end
          end
          DATA: begin
            if (fall) begin
              if (in_zero || in_one) begin
                shreg <= sh_nxt;
                if (bit_idx == IW'(NUM_BITS - 1)) begin
                  cmd       <= sh_nxt;
                  cmd_valid <= 1'b1;
                  state     <= IDLE;
                  bit_idx   <= '0;
                end else begin
                  bit_idx <= bit_idx + IW'(1);
                  state   <= GAP;
                end
              end else begin
                state   <= IDLE;
                err     <= 1'b1;
                bit_idx <= '0;
                shreg   <= '0;
              end
            end else if (cnt > 8'(ONE_MAX)) begin
              state   <= IDLE;
              err     <= 1'b1;
              bit_idx <= '0;
              shreg   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.CMD       = cmd;
  assign bus.CMD_VALID = cmd_valid;
  assign bus.ERR       = err;
  assign bus.BUSY      = (state != IDLE);
endmodule
